// File: rtl/fold_pkg.sv
// Shared fold-type bit positions, pattern codes with their lengths, and controller states.
package fold_pkg;

  localparam int T_NF  = 0;
  localparam int T_LV  = 1;
  localparam int T_OP  = 2;
  localparam int T_BG2 = 3;
  localparam int T_BG1 = 4;
  localparam int T_MEM = 5;

  localparam logic [3:0] PAT_SINGLE = 4'd0;
  localparam logic [3:0] PAT_LLOM   = 4'd1;
  localparam logic [3:0] PAT_LLO    = 4'd2;
  localparam logic [3:0] PAT_LLB2   = 4'd3;
  localparam logic [3:0] PAT_LOM    = 4'd4;
  localparam logic [3:0] PAT_LO     = 4'd5;
  localparam logic [3:0] PAT_LB1    = 4'd6;
  localparam logic [3:0] PAT_LB2    = 4'd7;
  localparam logic [3:0] PAT_LM     = 4'd8;
  localparam logic [3:0] PAT_OM     = 4'd9;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FLUSH = 2'd2
  } fold_state_e;

  function automatic logic [2:0] pat_cnt(input logic [3:0] pat);
    case (pat)
      PAT_LLOM:                              pat_cnt = 3'd4;
      PAT_LLO, PAT_LLB2, PAT_LOM:            pat_cnt = 3'd3;
      PAT_LO, PAT_LB1, PAT_LB2, PAT_LM,
      PAT_OM:                                pat_cnt = 3'd2;
      default:                               pat_cnt = 3'd1;
    endcase
  endfunction

  // Exact one-hot compare, so any illegal (non-one-hot) code never matches a real type.
  function automatic logic is_type(input logic [5:0] t, input int idx);
    logic [5:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    is_type = (t == oh);
  endfunction

endpackage

// File: rtl/fold_match.sv
// Picks the longest legal fold pattern from the four slot types and their valid bits.
// Purely combinational; no state.
module fold_match
  import fold_pkg::*;
(
  input  logic [5:0] type0,
  input  logic [5:0] type1,
  input  logic [5:0] type2,
  input  logic [5:0] type3,
  input  logic [3:0] inst_valid,
  input  logic       fold_en,
  output logic [3:0] pat,
  output logic [2:0] cnt
);

  logic lv0, op0, lv1, op1, bg1_1, bg2_1, mem1, op2, bg2_2, mem2, mem3;
  logic v2, v3, v4;

  assign lv0   = is_type(type0, T_LV);
  assign op0   = is_type(type0, T_OP);
  assign lv1   = is_type(type1, T_LV);
  assign op1   = is_type(type1, T_OP);
  assign bg1_1 = is_type(type1, T_BG1);
  assign bg2_1 = is_type(type1, T_BG2);
  assign mem1  = is_type(type1, T_MEM);
  assign op2   = is_type(type2, T_OP);
  assign bg2_2 = is_type(type2, T_BG2);
  assign mem2  = is_type(type2, T_MEM);
  assign mem3  = is_type(type3, T_MEM);

  assign v2 = &inst_valid[1:0];
  assign v3 = &inst_valid[2:0];
  assign v4 = &inst_valid[3:0];

  // Longest pattern first; an NF or illegal slot 0 falls through to SINGLE.
  always_comb begin
    pat = PAT_SINGLE;
    if (fold_en) begin
      if      (lv0 & lv1 & op2 & mem3 & v4) pat = PAT_LLOM;
      else if (lv0 & lv1 & op2 & v3)        pat = PAT_LLO;
      else if (lv0 & lv1 & bg2_2 & v3)      pat = PAT_LLB2;
      else if (lv0 & op1 & mem2 & v3)       pat = PAT_LOM;
      else if (lv0 & op1 & v2)              pat = PAT_LO;
      else if (lv0 & bg1_1 & v2)            pat = PAT_LB1;
      else if (lv0 & bg2_1 & v2)            pat = PAT_LB2;
      else if (lv0 & mem1 & v2)             pat = PAT_LM;
      else if (op0 & mem1 & v2)             pat = PAT_OM;
    end
    cnt = pat_cnt(pat);
  end

endmodule

// File: rtl/fold_grp_ctl.sv
// Fold-group controller: registers the chosen group for decode and shifts the ibuffer the same cycle.
// Group appears one cycle after load; held while iu_hold; optional counters under FOLD_GRP_STATS_EN.
module fold_grp_ctl
  import fold_pkg::*;
#(
  parameter int FOLD_WAIT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  type0,
  input  logic [5:0]  type1,
  input  logic [5:0]  type2,
  input  logic [5:0]  type3,
  input  logic [3:0]  inst_valid,
  input  logic        fold_en,
  input  logic        iu_hold,
  input  logic        flush,
  output logic [2:0]  ibuf_shift,
  output logic        grp_valid,
  output logic [2:0]  grp_cnt,
  output logic [3:0]  grp_pat,
  output logic [15:0] stat_grp,
  output logic [15:0] stat_saved
);

  localparam logic [3:0] FW4 = 4'(FOLD_WAIT);

  fold_state_e state, state_nxt;
  logic [3:0]  wait_cnt, wait_cnt_nxt;
  logic [3:0]  match_pat;
  logic [2:0]  match_cnt;
  logic        slot_free, wait_entry, load;

  fold_match u_match (
    .type0      (type0),
    .type1      (type1),
    .type2      (type2),
    .type3      (type3),
    .inst_valid (inst_valid),
    .fold_en    (fold_en),
    .pat        (match_pat),
    .cnt        (match_cnt)
  );

  assign slot_free  = ~grp_valid | ~iu_hold;
  assign wait_entry = is_type(type0, T_LV) & inst_valid[0] & ~inst_valid[1] &
                      (FOLD_WAIT > 0) & fold_en & slot_free;

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    load         = 1'b0;
    if (flush) begin
      state_nxt    = ST_FLUSH;
      wait_cnt_nxt = 4'd0;
    end else begin
      case (state)
        ST_RUN: begin
          if (wait_entry) begin
            state_nxt    = ST_WAIT;
            wait_cnt_nxt = 4'd1;
          end else begin
            load = inst_valid[0] & slot_free;
          end
        end
        ST_WAIT: begin
          // Slot 0 vanished: abandon the wait without issuing anything.
          if (!inst_valid[0]) begin
            state_nxt    = ST_RUN;
            wait_cnt_nxt = 4'd0;
          end else if (inst_valid[1] || wait_cnt == FW4) begin
            state_nxt    = ST_RUN;
            wait_cnt_nxt = 4'd0;
            load         = slot_free;
          end else begin
            wait_cnt_nxt = wait_cnt + 4'd1;
          end
        end
        default: begin
          state_nxt = ST_RUN;
        end
      endcase
    end
  end

  assign ibuf_shift = (load && !reset) ? match_cnt : 3'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_RUN;
      wait_cnt  <= 4'd0;
      grp_valid <= 1'b0;
      grp_cnt   <= 3'd0;
      grp_pat   <= 4'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (flush) begin
        grp_valid <= 1'b0;
      end else if (load) begin
        grp_valid <= 1'b1;
        grp_cnt   <= match_cnt;
        grp_pat   <= match_pat;
      end else if (!iu_hold) begin
        grp_valid <= 1'b0;
      end
    end
  end

`ifdef FOLD_GRP_STATS_EN
  logic [15:0] stat_grp_q, stat_saved_q;
  logic [16:0] saved_sum;

  assign saved_sum = {1'b0, stat_saved_q} + {14'd0, match_cnt - 3'd1};

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_grp_q   <= 16'd0;
      stat_saved_q <= 16'd0;
    end else if (load && match_cnt > 3'd1) begin
      if (stat_grp_q != 16'hFFFF) stat_grp_q <= stat_grp_q + 16'd1;
      stat_saved_q <= saved_sum[16] ? 16'hFFFF : saved_sum[15:0];
    end
  end

  assign stat_grp   = stat_grp_q;
  assign stat_saved = stat_saved_q;
`else
  assign stat_grp   = 16'd0;
  assign stat_saved = 16'd0;
`endif

endmodule

// File: tb/tb_fold_grp_ctl.sv
// Bench for fold_grp_ctl: directed test-plan scenarios, then random traffic against a table-driven model.
module tb_fold_grp_ctl;

  localparam int FW = 2;
  localparam logic [5:0] T_NF  = 6'h01;
  localparam logic [5:0] T_LV  = 6'h02;
  localparam logic [5:0] T_OP  = 6'h04;
  localparam logic [5:0] T_BG2 = 6'h08;
  localparam logic [5:0] T_BG1 = 6'h10;
  localparam logic [5:0] T_MEM = 6'h20;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  type0, type1, type2, type3;
  logic [3:0]  inst_valid;
  logic        fold_en, iu_hold, flush;
  logic [2:0]  ibuf_shift;
  logic        grp_valid;
  logic [2:0]  grp_cnt;
  logic [3:0]  grp_pat;
  logic [15:0] stat_grp, stat_saved;

  always #5 clk = ~clk;

  fold_grp_ctl #(.FOLD_WAIT(FW)) dut (
    .clk        (clk),
    .reset      (reset),
    .type0      (type0),
    .type1      (type1),
    .type2      (type2),
    .type3      (type3),
    .inst_valid (inst_valid),
    .fold_en    (fold_en),
    .iu_hold    (iu_hold),
    .flush      (flush),
    .ibuf_shift (ibuf_shift),
    .grp_valid  (grp_valid),
    .grp_cnt    (grp_cnt),
    .grp_pat    (grp_pat),
    .stat_grp   (stat_grp),
    .stat_saved (stat_saved)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Pattern table: code -> ordered slot types; code 0 (SINGLE) is the fallback.
  int         pat_len [10];
  logic [5:0] pat_ty  [10][4];

  // Reference model state: mode 0=running, 1=waiting for slot 1, 2=post-flush bubble.
  int         m_mode, m_wait;
  logic       m_valid;
  logic [2:0] m_cnt;
  logic [3:0] m_pat;
  int         m_sg, m_ss;
  int         exp_shift;
  logic [2:0] obs_shift;

  function automatic void ref_match(output int code, output int len);
    logic [5:0] tv[4];
    logic ok;
    tv   = '{type0, type1, type2, type3};
    code = 0;
    len  = 1;
    if (fold_en) begin
      for (int i = 1; i < 10; i++) begin
        ok = 1'b1;
        for (int k = 0; k < pat_len[i]; k++)
          if (tv[k] !== pat_ty[i][k] || inst_valid[k] !== 1'b1) ok = 1'b0;
        if (ok && code == 0) begin
          code = i;
          len  = pat_len[i];
        end
      end
    end
  endfunction

  task automatic model_step();
    int code, len;
    logic free, load;
    ref_match(code, len);
    load = 1'b0;
    exp_shift = 0;
    if (reset) begin
      m_mode = 0; m_wait = 0; m_valid = 1'b0; m_cnt = 3'd0; m_pat = 4'd0;
      m_sg = 0; m_ss = 0;
    end else if (flush) begin
      m_mode = 2; m_wait = 0; m_valid = 1'b0;
    end else begin
      free = !m_valid || !iu_hold;
      if (m_mode == 2) begin
        m_mode = 0;
      end else if (m_mode == 0) begin
        if (type0 == T_LV && inst_valid[0] && !inst_valid[1] && FW > 0 && fold_en && free) begin
          m_mode = 1; m_wait = 1;
        end else begin
          load = inst_valid[0] && free;
        end
      end else begin
        if (!inst_valid[0]) begin
          m_mode = 0; m_wait = 0;
        end else if (inst_valid[1] || m_wait == FW) begin
          m_mode = 0; m_wait = 0; load = free;
        end else begin
          m_wait = m_wait + 1;
        end
      end
      if (load) begin
        exp_shift = len;
        m_valid = 1'b1;
        m_cnt = 3'(len);
        m_pat = 4'(code);
`ifdef FOLD_GRP_STATS_EN
        if (len > 1) begin
          m_sg = (m_sg + 1 > 65535) ? 65535 : m_sg + 1;
          m_ss = (m_ss + len - 1 > 65535) ? 65535 : m_ss + len - 1;
        end
`endif
      end else if (!iu_hold) begin
        m_valid = 1'b0;
      end
    end
  endtask

  // One clock: sample the combinational shift, advance the model, then let the edge happen.
  task automatic cycle();
    #1;
    obs_shift = ibuf_shift;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_types(input logic [5:0] a, b, c, d);
    type0 = a; type1 = b; type2 = c; type3 = d;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; iu_hold = 1'b0; fold_en = 1'b1;
    set_types(T_LV, T_LV, T_OP, T_MEM);
    inst_valid = 4'hF;
    cycle();
    cycle();
    n_chk++; if (obs_shift !== 3'd0) begin n_fail++; $display("FAIL reset_shift: got %0d want 0", obs_shift); end
    n_chk++; if (grp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", grp_valid); end
    n_chk++; if (grp_cnt !== 3'd0 || grp_pat !== 4'd0) begin n_fail++; $display("FAIL reset_grp: got cnt %0d pat %0d want 0 0", grp_cnt, grp_pat); end
    n_chk++; if (stat_grp !== 16'd0 || stat_saved !== 16'd0) begin n_fail++; $display("FAIL reset_stats: got %0d %0d want 0 0", stat_grp, stat_saved); end
    reset = 1'b0;
  endtask

  task automatic test_long_group();
    set_types(T_LV, T_LV, T_OP, T_MEM);
    inst_valid = 4'hF; fold_en = 1'b1;
    cycle();
    n_chk++; if (obs_shift !== 3'd4) begin n_fail++; $display("FAIL llom_shift: got %0d want 4", obs_shift); end
    n_chk++; if (grp_valid !== 1'b1 || grp_pat !== 4'd1 || grp_cnt !== 3'd4) begin n_fail++; $display("FAIL llom_grp: got v%0b pat %0d cnt %0d want v1 pat 1 cnt 4", grp_valid, grp_pat, grp_cnt); end
    n_chk++; if (stat_grp !== 16'(m_sg) || stat_saved !== 16'(m_ss)) begin n_fail++; $display("FAIL llom_stats: got %0d %0d want %0d %0d", stat_grp, stat_saved, m_sg, m_ss); end
    fold_en = 1'b0;
    cycle();
    n_chk++; if (obs_shift !== 3'd1) begin n_fail++; $display("FAIL nofold_shift: got %0d want 1", obs_shift); end
    n_chk++; if (grp_valid !== 1'b1 || grp_pat !== 4'd0 || grp_cnt !== 3'd1) begin n_fail++; $display("FAIL nofold_grp: got v%0b pat %0d cnt %0d want v1 pat 0 cnt 1", grp_valid, grp_pat, grp_cnt); end
    fold_en = 1'b1;
  endtask

  task automatic test_partial_valid();
    set_types(T_LV, T_OP, T_MEM, T_NF);
    inst_valid = 4'b0011;
    cycle();
    n_chk++; if (obs_shift !== 3'd2) begin n_fail++; $display("FAIL partial_shift: got %0d want 2", obs_shift); end
    n_chk++; if (grp_pat !== 4'd5 || grp_cnt !== 3'd2) begin n_fail++; $display("FAIL partial_grp: got pat %0d cnt %0d want 5 2", grp_pat, grp_cnt); end
  endtask

  task automatic test_wait();
    set_types(T_LV, T_BG1, T_NF, T_NF);
    inst_valid = 4'b0001;
    cycle();
    n_chk++; if (obs_shift !== 3'd0) begin n_fail++; $display("FAIL wait_c1_shift: got %0d want 0", obs_shift); end
    n_chk++; if (grp_valid !== 1'b0) begin n_fail++; $display("FAIL wait_c1_valid: got %0b want 0", grp_valid); end
    cycle();
    n_chk++; if (obs_shift !== 3'd0) begin n_fail++; $display("FAIL wait_c2_shift: got %0d want 0", obs_shift); end
    cycle();
    n_chk++; if (obs_shift !== 3'd1) begin n_fail++; $display("FAIL wait_timeout_shift: got %0d want 1", obs_shift); end
    n_chk++; if (grp_valid !== 1'b1 || grp_pat !== 4'd0 || grp_cnt !== 3'd1) begin n_fail++; $display("FAIL wait_timeout_grp: got v%0b pat %0d cnt %0d want v1 pat 0 cnt 1", grp_valid, grp_pat, grp_cnt); end
    cycle();
    n_chk++; if (obs_shift !== 3'd0) begin n_fail++; $display("FAIL wait2_c1_shift: got %0d want 0", obs_shift); end
    inst_valid = 4'b0011;
    cycle();
    n_chk++; if (obs_shift !== 3'd2) begin n_fail++; $display("FAIL wait2_arrive_shift: got %0d want 2", obs_shift); end
    n_chk++; if (grp_valid !== 1'b1 || grp_pat !== 4'd6 || grp_cnt !== 3'd2) begin n_fail++; $display("FAIL wait2_grp: got v%0b pat %0d cnt %0d want v1 pat 6 cnt 2", grp_valid, grp_pat, grp_cnt); end
  endtask

  task automatic test_hold();
    set_types(T_LV, T_OP, T_NF, T_NF);
    inst_valid = 4'hF; iu_hold = 1'b0;
    cycle();
    n_chk++; if (obs_shift !== 3'd2) begin n_fail++; $display("FAIL hold_load_shift: got %0d want 2", obs_shift); end
    iu_hold = 1'b1;
    set_types(T_OP, T_MEM, T_NF, T_NF);
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_chk++; if (obs_shift !== 3'd0) begin n_fail++; $display("FAIL hold_shift[%0d]: got %0d want 0", i, obs_shift); end
      n_chk++; if (grp_valid !== 1'b1 || grp_pat !== 4'd5 || grp_cnt !== 3'd2) begin n_fail++; $display("FAIL hold_grp[%0d]: got v%0b pat %0d cnt %0d want v1 pat 5 cnt 2", i, grp_valid, grp_pat, grp_cnt); end
    end
    iu_hold = 1'b0;
    cycle();
    n_chk++; if (obs_shift !== 3'd2) begin n_fail++; $display("FAIL release_shift: got %0d want 2", obs_shift); end
    n_chk++; if (grp_valid !== 1'b1 || grp_pat !== 4'd9) begin n_fail++; $display("FAIL release_grp: got v%0b pat %0d want v1 pat 9", grp_valid, grp_pat); end
  endtask

  task automatic test_flush_wait();
    set_types(T_LV, T_NF, T_NF, T_NF);
    inst_valid = 4'b0001; iu_hold = 1'b0;
    cycle();
    n_chk++; if (obs_shift !== 3'd0) begin n_fail++; $display("FAIL fw_enter_shift: got %0d want 0", obs_shift); end
    flush = 1'b1; iu_hold = 1'b1;
    cycle();
    n_chk++; if (obs_shift !== 3'd0) begin n_fail++; $display("FAIL fw_flush_shift: got %0d want 0", obs_shift); end
    n_chk++; if (grp_valid !== 1'b0) begin n_fail++; $display("FAIL fw_flush_valid: got %0b want 0", grp_valid); end
    flush = 1'b0; iu_hold = 1'b0;
    set_types(T_LV, T_LV, T_OP, T_MEM);
    inst_valid = 4'hF;
    cycle();
    n_chk++; if (obs_shift !== 3'd0) begin n_fail++; $display("FAIL fw_bubble_shift: got %0d want 0", obs_shift); end
    n_chk++; if (stat_grp !== 16'(m_sg) || stat_saved !== 16'(m_ss)) begin n_fail++; $display("FAIL fw_stats: got %0d %0d want %0d %0d", stat_grp, stat_saved, m_sg, m_ss); end
    cycle();
    n_chk++; if (obs_shift !== 3'd4) begin n_fail++; $display("FAIL fw_resume_shift: got %0d want 4", obs_shift); end
    n_chk++; if (grp_valid !== 1'b1 || grp_pat !== 4'd1) begin n_fail++; $display("FAIL fw_resume_grp: got v%0b pat %0d want v1 pat 1", grp_valid, grp_pat); end
  endtask

  function automatic logic [5:0] rnd_type();
    case ($urandom_range(0, 10))
      0, 1, 2: rnd_type = T_LV;
      3, 4:    rnd_type = T_OP;
      5:       rnd_type = T_MEM;
      6:       rnd_type = T_BG1;
      7:       rnd_type = T_BG2;
      8:       rnd_type = T_NF;
      9:       rnd_type = 6'h06;
      default: rnd_type = 6'h00;
    endcase
  endfunction

  task automatic test_random();
    int n;
    for (int c = 0; c < 600; c++) begin
      set_types(rnd_type(), rnd_type(), rnd_type(), rnd_type());
      if ($urandom_range(0, 3) != 0) begin
        n = $urandom_range(0, 4);
        inst_valid = 4'((1 << n) - 1);
      end else begin
        inst_valid = 4'($urandom_range(0, 15));
      end
      fold_en = ($urandom_range(0, 7) != 0);
      iu_hold = ($urandom_range(0, 2) == 0);
      flush   = ($urandom_range(0, 15) == 0);
      reset   = ($urandom_range(0, 149) == 0);
      cycle();
      n_chk++; if (obs_shift !== 3'(exp_shift)) begin n_fail++; $display("FAIL rnd_shift@%0d: got %0d want %0d", c, obs_shift, exp_shift); end
      n_chk++; if (grp_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid@%0d: got %0b want %0b", c, grp_valid, m_valid); end
      n_chk++; if (grp_cnt !== m_cnt || grp_pat !== m_pat) begin n_fail++; $display("FAIL rnd_grp@%0d: got cnt %0d pat %0d want cnt %0d pat %0d", c, grp_cnt, grp_pat, m_cnt, m_pat); end
      n_chk++; if (stat_grp !== 16'(m_sg) || stat_saved !== 16'(m_ss)) begin n_fail++; $display("FAIL rnd_stats@%0d: got %0d %0d want %0d %0d", c, stat_grp, stat_saved, m_sg, m_ss); end
    end
    reset = 1'b0; flush = 1'b0; iu_hold = 1'b0;
  endtask

  initial begin
    pat_len[0] = 1; pat_ty[0] = '{T_NF,  T_NF,  T_NF,  T_NF};
    pat_len[1] = 4; pat_ty[1] = '{T_LV,  T_LV,  T_OP,  T_MEM};
    pat_len[2] = 3; pat_ty[2] = '{T_LV,  T_LV,  T_OP,  T_NF};
    pat_len[3] = 3; pat_ty[3] = '{T_LV,  T_LV,  T_BG2, T_NF};
    pat_len[4] = 3; pat_ty[4] = '{T_LV,  T_OP,  T_MEM, T_NF};
    pat_len[5] = 2; pat_ty[5] = '{T_LV,  T_OP,  T_NF,  T_NF};
    pat_len[6] = 2; pat_ty[6] = '{T_LV,  T_BG1, T_NF,  T_NF};
    pat_len[7] = 2; pat_ty[7] = '{T_LV,  T_BG2, T_NF,  T_NF};
    pat_len[8] = 2; pat_ty[8] = '{T_LV,  T_MEM, T_NF,  T_NF};
    pat_len[9] = 2; pat_ty[9] = '{T_OP,  T_MEM, T_NF,  T_NF};
    m_mode = 0; m_wait = 0; m_valid = 1'b0; m_cnt = 3'd0; m_pat = 4'd0;
    m_sg = 0; m_ss = 0; exp_shift = 0;
    reset = 1'b1; flush = 1'b0; iu_hold = 1'b0; fold_en = 1'b1;
    inst_valid = 4'h0;
    set_types(T_NF, T_NF, T_NF, T_NF);
    @(posedge clk);
    #1;
    test_reset();
    test_long_group();
    test_partial_valid();
    test_wait();
    test_hold();
    test_flush_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
